// File: rtl/kyber_pkg.sv
// Shared Kyber arithmetic definitions: default modulus/width, Barrett constants,
// butterfly mode encodings and small modular helper functions.
package kyber_pkg;

  localparam int KYBER_WIDTH   = 12;
  localparam int KYBER_Q       = 3329;
  localparam int BARRETT_SHIFT = 2 * KYBER_WIDTH;
  localparam int BARRETT_M     = (1 << BARRETT_SHIFT) / KYBER_Q;  // 5039

  typedef enum logic [1:0] {
    MODE_NTT       = 2'd0,
    MODE_INTT      = 2'd1,
    MODE_BYPASS    = 2'd2,
    MODE_INTT_HALF = 2'd3
  } mode_e;

  // Helpers work on 32-bit values so any WIDTH up to 30 bits can share them;
  // operands are assumed already reduced into [0,q-1].
  function automatic logic [31:0] add_mod(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] q);
    logic [31:0] s;
    s = x + y;
    return (s >= q) ? s - q : s;
  endfunction

  function automatic logic [31:0] sub_mod(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] q);
    return (x >= y) ? x - y : x + q - y;
  endfunction

  // Multiply by 2^-1 mod q (q odd): odd values borrow one q to become even.
  function automatic logic [31:0] halve(input logic [31:0] x, input logic [31:0] q);
    return x[0] ? ((x + q) >> 1) : (x >> 1);
  endfunction

  function automatic logic is_intt(input mode_e m);
    return (m == MODE_INTT) || (m == MODE_INTT_HALF);
  endfunction

endpackage

// File: rtl/barrett_reduce.sv
// Combinational Barrett reduction of a 2*WIDTH-bit product modulo Q.
// Quotient estimate is at most one low, so a single correction suffices.
module barrett_reduce #(
  parameter int WIDTH = 12,
  parameter int Q     = 3329
) (
  input  logic [2*WIDTH-1:0] x,
  output logic [WIDTH-1:0]   r
);

  localparam longint unsigned M_FULL = (64'd1 << (2 * WIDTH)) / 64'(Q);
  localparam logic [WIDTH:0]     M  = (WIDTH + 1)'(M_FULL);
  localparam logic [2*WIDTH-1:0] QX = (2 * WIDTH)'(Q);

  logic [3*WIDTH:0]   xm;
  logic [WIDTH:0]     qhat;
  logic [2*WIDTH-1:0] qq;
  logic [2*WIDTH-1:0] diff;

  assign xm   = (3 * WIDTH + 1)'(x) * (3 * WIDTH + 1)'(M);
  assign qhat = (WIDTH + 1)'(xm >> (2 * WIDTH));
  assign qq   = (2 * WIDTH)'(qhat) * QX;
  assign diff = x - qq;
  assign r    = WIDTH'((diff >= QX) ? diff - QX : diff);

endmodule

// File: rtl/butterfly_pipe.sv
// Four-stage pipelined Kyber butterfly (NTT / INTT / INTT_HALF / BYPASS) with
// valid/ready flow control; a single advance signal moves every stage together.
module butterfly_pipe
  import kyber_pkg::*;
#(
  parameter int WIDTH = KYBER_WIDTH,
  parameter int Q     = KYBER_Q,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] w,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [TAG_W-1:0] tag_out
);

  localparam logic [31:0] QW = 32'(Q);

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  mode_e mode_in;
  assign mode_in = mode_e'(sel);

  // S1: x carries the "first" operand (a, or a+b for INTT), y the multiplicand.
  logic             v1_reg;
  mode_e            mode1_reg;
  logic [WIDTH-1:0] x1_reg, y1_reg, w1_reg;
  logic [TAG_W-1:0] tag1_reg;
  logic [WIDTH-1:0] x1_next, y1_next;

  always_comb begin
    x1_next = a;
    y1_next = b;
    if (is_intt(mode_in)) begin
      x1_next = WIDTH'(add_mod(32'(a), 32'(b), QW));
      y1_next = WIDTH'(sub_mod(32'(a), 32'(b), QW));
    end
  end

  // S2: raw product
  logic               v2_reg;
  mode_e              mode2_reg;
  logic [WIDTH-1:0]   x2_reg, y2_reg;
  logic [TAG_W-1:0]   tag2_reg;
  logic [2*WIDTH-1:0] prod2_reg;

  // S3: reduced product
  logic             v3_reg;
  mode_e            mode3_reg;
  logic [WIDTH-1:0] x3_reg, y3_reg, t3_reg;
  logic [TAG_W-1:0] tag3_reg;
  logic [WIDTH-1:0] t3_next;

  barrett_reduce #(
    .WIDTH(WIDTH),
    .Q    (Q)
  ) u_barrett (
    .x(prod2_reg),
    .r(t3_next)
  );

  // S4: final combine; y3 survives only so BYPASS can return b untouched.
  logic [WIDTH-1:0] c_next, d_next;

  always_comb begin
    c_next = x3_reg;
    d_next = t3_reg;
    case (mode3_reg)
      MODE_NTT: begin
        c_next = WIDTH'(add_mod(32'(x3_reg), 32'(t3_reg), QW));
        d_next = WIDTH'(sub_mod(32'(x3_reg), 32'(t3_reg), QW));
      end
      MODE_INTT_HALF: begin
        c_next = WIDTH'(halve(32'(x3_reg), QW));
        d_next = WIDTH'(halve(32'(t3_reg), QW));
      end
      MODE_BYPASS: d_next = y3_reg;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      v3_reg    <= 1'b0;
      out_valid <= 1'b0;
      mode1_reg <= MODE_NTT;
      mode2_reg <= MODE_NTT;
      mode3_reg <= MODE_NTT;
      x1_reg    <= '0;
      y1_reg    <= '0;
      w1_reg    <= '0;
      tag1_reg  <= '0;
      x2_reg    <= '0;
      y2_reg    <= '0;
      tag2_reg  <= '0;
      prod2_reg <= '0;
      x3_reg    <= '0;
      y3_reg    <= '0;
      t3_reg    <= '0;
      tag3_reg  <= '0;
      c         <= '0;
      d         <= '0;
      tag_out   <= '0;
    end else if (advance) begin
      v1_reg    <= in_valid;
      mode1_reg <= mode_in;
      x1_reg    <= x1_next;
      y1_reg    <= y1_next;
      w1_reg    <= w;
      tag1_reg  <= tag_in;

      v2_reg    <= v1_reg;
      mode2_reg <= mode1_reg;
      x2_reg    <= x1_reg;
      y2_reg    <= y1_reg;
      tag2_reg  <= tag1_reg;
      prod2_reg <= (2 * WIDTH)'(w1_reg) * (2 * WIDTH)'(y1_reg);

      v3_reg    <= v2_reg;
      mode3_reg <= mode2_reg;
      x3_reg    <= x2_reg;
      y3_reg    <= y2_reg;
      t3_reg    <= t3_next;
      tag3_reg  <= tag2_reg;

      out_valid <= v3_reg;
      c         <= c_next;
      d         <= d_next;
      tag_out   <= tag3_reg;
    end
  end

endmodule

// File: doc/butterfly_pipe.md
Name: butterfly_pipe

Overview:
- Pipelined, parametrised Kyber butterfly. Successor to the single-stage butterfly.
- Computes Cooley-Tukey (NTT), Gentleman-Sande (INTT), INTT-with-halving, or bypass on coefficient pairs.
- Reduction is modulo a parametrised prime Q using Barrett.
- Sits between the polynomial RAM read ports and write-back in the poly unit. Valid/ready handshake and a tag pass-through carry write-back addresses.

Parameters:
- WIDTH, 12, coefficient/twiddle width. Q < 2^WIDTH.
- Q, 3329, modulus.
- TAG_W, 8, width of the opaque tag carried with each operation.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready at rising edge
- sel  in  2  mode: 0 NTT, 1 INTT, 2 BYPASS, 3 INTT_HALF; sampled with the operation
- a  in  WIDTH  first coefficient
- b  in  WIDTH  second coefficient
- w  in  WIDTH  twiddle
- tag_in  in  TAG_W  opaque tag
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready at rising edge
- c  out  WIDTH  first result
- d  out  WIDTH  second result
- tag_out  out  TAG_W  tag of the result

Behaviour:
- Reset: one clock, synchronous, active-high, as already decided. At rst=1, every stage valid bit and out_valid go to 0, and c, d, tag_out go to 0. Reset mid-stream discards all in-flight operations; out_valid=0 after that edge.
- Pipeline: 4 register stages.
  - S1: capture a, b, w, sel, tag. For INTT modes, form s=a+b mod Q and u=a-b mod Q.
  - S2: multiply; operand is b (NTT) or u (INTT modes).
  - S3: Barrett reduce.
  - S4: final add/sub and halving; drives outputs.
- Latency: operation accepted at edge k appears with out_valid=1 immediately after edge k+3, provided no stall.
- Flow control: global advance = !out_valid || out_ready.
  - All stages shift on advance; in_ready = advance (combinational).
  - Bubbles do not collapse.
  - While stalled, all stage contents and outputs hold stable.
  - Throughput is 1 op/cycle when out_ready=1.
- Arithmetic. Inputs a, b, w are required to be in [0,Q-1] for NTT/INTT modes; otherwise results are unspecified but handshake timing is unaffected.
  - NTT: t = w*b mod Q; c = a+t mod Q; d = a-t mod Q.
  - INTT: c = a+b mod Q; d = (a-b)*w mod Q.
  - INTT_HALF: as INTT, then each result is halved mod Q: x even -> x/2, x odd -> (x+Q)/2.
  - BYPASS: c = a, d = b, raw WIDTH bits, no reduction, same 4-cycle latency.
- Barrett: K=WIDTH, M=floor(2^(2K)/Q) (5039 for defaults).
  - Compute r = x - ((x*M)>>(2K))*Q, then at most one conditional subtract of Q.
  - Product width 2*WIDTH; intermediate x*M width 3*WIDTH+1.
- Mod add/sub: single conditional correction. All outputs are in [0,Q-1] except BYPASS.
- Ordering: results leave in acceptance order; tag_out always matches its operation.
- Simultaneous in/out handshake on a full pipe is legal and sustains full rate.

Decomposition:
- Shared package kyber_pkg holds:
  - constants Q, WIDTH, Barrett constant and shift;
  - mode encodings MODE_NTT=0, MODE_INTT=1, MODE_BYPASS=2, MODE_INTT_HALF=3;
  - halve and mod add/sub functions.
- One sub-module, barrett_reduce: combinational core of S3, with the registered wrapper in butterfly_pipe.

Test Plan:
- Reset held 3 cycles, then released with in_valid=0 -> out_valid=0, c=d=0, tag_out=0, in_ready=1.
- NTT a=100, b=2, w=17, tag=0x11 -> after edge k+3: c=134, d=66, tag_out=0x11. NTT a=5, b=10, w=1000 -> c=18, d=3321.
- INTT a=10, b=3, w=17 -> c=13, d=119. INTT_HALF with the same inputs -> c=1671, d=1724.
- BYPASS a=4095, b=7, w=0 -> c=4095, d=7 with 4-cycle latency.
- Six back-to-back ops with tags 1..6; out_ready low for 3 cycles mid-stream -> in_ready low while stalled, outputs stable, all six delivered once, in order, with correct values.
- Stream in flight, rst pulsed 1 cycle -> out_valid=0 next cycle; no pre-reset op ever emitted; a new op after reset returns with correct 4-cycle latency.
